// File: rtl/phy_pkg.sv
// Shared widths, phase/state/source encodings and the byte-select helper
// for the PHY transmit byte scheduler.
package phy_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef logic [1:0] phase_t;
  localparam phase_t PH_B3 = 2'd0;
  localparam phase_t PH_B2 = 2'd1;
  localparam phase_t PH_B1 = 2'd2;
  localparam phase_t PH_B0 = 2'd3;

  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;
  typedef enum logic {SRC_DAT = 1'b0, SRC_CTL = 1'b1} src_t;

  // Phase 0 drives the MSB byte, phase 3 the LSB byte.
  function automatic logic [BYTE_W-1:0] sel_byte(input logic [WORD_W-1:0] w, input phase_t p);
    case (p)
      PH_B3:   sel_byte = w[31:24];
      PH_B2:   sel_byte = w[23:16];
      PH_B1:   sel_byte = w[15:8];
      default: sel_byte = w[7:0];
    endcase
  endfunction
endpackage

// File: rtl/phy_word_ser.sv
// Word hold register, phase counter and registered byte mux; emits one
// byte per clock MSB-first and clears itself after the last byte.
module phy_word_ser
  import phy_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              adv_i,
  input  logic              hold_i,
  output logic [BYTE_W-1:0] byte_out_o,
  output logic              byte_valid_o,
  output logic              last_o
);
  logic [WORD_W-1:0] word_q, word_d;
  phase_t            phase_q, phase_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              valid_q, valid_d;

  always_comb begin
    word_d  = word_q;
    phase_d = phase_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    if (load_i) begin
      word_d  = word_i;
      phase_d = PH_B3;
      byte_d  = sel_byte(word_i, PH_B3);
      valid_d = 1'b1;
    end else if (adv_i && !hold_i) begin
      if (phase_q == PH_B0) begin
        phase_d = PH_B3;
        byte_d  = '0;
        valid_d = 1'b0;
      end else begin
        phase_d = phase_t'(phase_q + 2'd1);
        byte_d  = sel_byte(word_q, phase_t'(phase_q + 2'd1));
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q  <= '0;
      phase_q <= PH_B3;
      byte_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      phase_q <= phase_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

  assign byte_out_o   = byte_q;
  assign byte_valid_o = valid_q;
  assign last_o       = valid_q && (phase_q == PH_B0);
endmodule

// File: rtl/phy_byte_scheduler.sv
// Arbitrates ordered-set and data words onto the single TX byte lane.
// Define PHY_ARB_RR_EN for round-robin grant instead of ctl-first priority.
module phy_byte_scheduler
  import phy_pkg::*;
(
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [WORD_W-1:0] dat_word,
  input  logic              dat_valid,
  output logic              dat_ready,
  input  logic [WORD_W-1:0] ctl_word,
  input  logic              ctl_valid,
  output logic              ctl_ready,
  input  logic              hold,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              byte_ctl,
  output logic              busy
);
  state_t state_q;
  logic   byte_ctl_q;
  logic   ser_last, slot_open, ctl_acc, dat_acc, load;

  assign slot_open = !hold && ((state_q == ST_IDLE) || ser_last);

`ifdef PHY_ARB_RR_EN
  logic rr_q;  // 1: ctl preferred on contention
  assign ctl_ready = slot_open && ctl_valid && (!dat_valid || rr_q);
  assign dat_ready = slot_open && dat_valid && (!ctl_valid || !rr_q);
`else
  assign ctl_ready = slot_open && ctl_valid;
  assign dat_ready = slot_open && dat_valid && !ctl_valid;
`endif

  assign ctl_acc = ctl_ready && ctl_valid;
  assign dat_acc = dat_ready && dat_valid;
  assign load    = ctl_acc || dat_acc;

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      byte_ctl_q <= SRC_DAT;
    end else if (load) begin
      state_q    <= ST_SEND;
      byte_ctl_q <= ctl_acc ? SRC_CTL : SRC_DAT;
    end else if (!hold && state_q == ST_SEND && ser_last) begin
      state_q    <= ST_IDLE;
      byte_ctl_q <= SRC_DAT;
    end
  end

`ifdef PHY_ARB_RR_EN
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset)    rr_q <= 1'b1;
    else if (load) rr_q <= !ctl_acc;
  end
`endif

  phy_word_ser u_ser (
    .clk_i       (clk_4f),
    .rst_ni      (reset),
    .load_i      (load),
    .word_i      (ctl_acc ? ctl_word : dat_word),
    .adv_i       (state_q == ST_SEND),
    .hold_i      (hold),
    .byte_out_o  (byte_out),
    .byte_valid_o(byte_valid),
    .last_o      (ser_last)
  );

  assign byte_ctl = byte_ctl_q;
  assign busy     = (state_q == ST_SEND);
endmodule

// File: tb/tb_phy_byte_scheduler.sv
// Directed table-driven bench for phy_byte_scheduler plus hand sequences
// for reset state and asynchronous reset mid-word.
module tb_phy_byte_scheduler;
  logic        clk_4f = 1'b0;
  logic        reset;
  logic [31:0] dat_word, ctl_word;
  logic        dat_valid, ctl_valid, dat_ready, ctl_ready, hold;
  logic [7:0]  byte_out;
  logic        byte_valid, byte_ctl, busy;

  int checks = 0;
  int failures = 0;

  always #5 clk_4f = ~clk_4f;

  phy_byte_scheduler dut (
    .clk_4f(clk_4f), .reset(reset),
    .dat_word(dat_word), .dat_valid(dat_valid), .dat_ready(dat_ready),
    .ctl_word(ctl_word), .ctl_valid(ctl_valid), .ctl_ready(ctl_ready),
    .hold(hold), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ctl(byte_ctl), .busy(busy)
  );

  typedef struct {
    logic        dv;
    logic [31:0] dw;
    logic        cv;
    logic [31:0] cw;
    logic        hd;
    logic        exp_dr;
    logic        exp_cr;
    logic [7:0]  exp_byte;
    logic        exp_v;
    logic        exp_c;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic dv, input logic [31:0] dw, input logic cv, input logic [31:0] cw,
                     input logic hd, input logic edr, input logic ecr, input logic [7:0] eb,
                     input logic ev, input logic ec, input logic ebz);
    vec_t v;
    v.dv = dv; v.dw = dw; v.cv = cv; v.cw = cw; v.hd = hd;
    v.exp_dr = edr; v.exp_cr = ecr; v.exp_byte = eb;
    v.exp_v = ev; v.exp_c = ec; v.exp_busy = ebz;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  localparam logic [31:0] C = 32'hBCBCBCBC;
  localparam logic [31:0] D = 32'h11223344;
  localparam logic [31:0] W = 32'h9ABCDE01;

  initial begin
    reset = 1'b0; dat_word = '0; ctl_word = '0; dat_valid = 0; ctl_valid = 0; hold = 0;
    #12;
    chk("rst_byte_out", byte_out, 8'h00);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_byte_ctl", byte_ctl, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk_4f); reset = 1'b1;

    // single data word
    add(1, 32'hA1B2C3D4, 0, 0, 0, 1, 0, 8'hA1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'hB2, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'hC3, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'hD4, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    // back-to-back data words
    add(1, 32'h01020304, 0, 0, 0, 1, 0, 8'h01, 1, 0, 1);
    add(1, 32'h05060708, 0, 0, 0, 0, 0, 8'h02, 1, 0, 1);
    add(1, 32'h05060708, 0, 0, 0, 0, 0, 8'h03, 1, 0, 1);
    add(1, 32'h05060708, 0, 0, 0, 0, 0, 8'h04, 1, 0, 1);
    add(1, 32'h05060708, 0, 0, 0, 1, 0, 8'h05, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'h06, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'h07, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'h08, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    // hold at p=1, then hold across p==3 closing the slot
    add(1, 32'hDEADBEEF, 0, 0, 0, 1, 0, 8'hDE, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'hAD, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 8'hAD, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 8'hAD, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 8'hAD, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'hBE, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'hEF, 1, 0, 1);
    add(1, W, 0, 0, 1, 0, 0, 8'hEF, 1, 0, 1);
    add(1, W, 0, 0, 0, 1, 0, 8'h9A, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'hBC, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'hDE, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'h01, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
`ifdef PHY_ARB_RR_EN
    // contention, round-robin: ctl, dat, ctl, dat
    for (int w = 0; w < 4; w++) begin
      logic g_ctl;
      g_ctl = (w % 2 == 0);
      add(1, D, 1, C, 0, !g_ctl, g_ctl, g_ctl ? 8'hBC : 8'h11, 1, g_ctl, 1);
      add(1, D, 1, C, 0, 0, 0, g_ctl ? 8'hBC : 8'h22, 1, g_ctl, 1);
      add(1, D, 1, C, 0, 0, 0, g_ctl ? 8'hBC : 8'h33, 1, g_ctl, 1);
      add(1, D, 1, C, 0, 0, 0, g_ctl ? 8'hBC : 8'h44, 1, g_ctl, 1);
    end
    add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
`else
    // contention, fixed priority: ctl first, dat waits
    add(1, D, 1, C, 0, 0, 1, 8'hBC, 1, 1, 1);
    add(1, D, 1, C, 0, 0, 0, 8'hBC, 1, 1, 1);
    add(1, D, 1, C, 0, 0, 0, 8'hBC, 1, 1, 1);
    add(1, D, 1, C, 0, 0, 0, 8'hBC, 1, 1, 1);
    add(1, D, 0, 0, 0, 1, 0, 8'h11, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'h22, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'h33, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'h44, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
`endif

    foreach (tbl[i]) begin
      @(negedge clk_4f);
      dat_valid = tbl[i].dv; dat_word = tbl[i].dw;
      ctl_valid = tbl[i].cv; ctl_word = tbl[i].cw; hold = tbl[i].hd;
      #1;
      chk($sformatf("v%0d_dat_ready", i), dat_ready, tbl[i].exp_dr);
      chk($sformatf("v%0d_ctl_ready", i), ctl_ready, tbl[i].exp_cr);
      @(posedge clk_4f); #1;
      chk($sformatf("v%0d_byte_out", i), byte_out, tbl[i].exp_byte);
      chk($sformatf("v%0d_byte_valid", i), byte_valid, tbl[i].exp_v);
      chk($sformatf("v%0d_byte_ctl", i), byte_ctl, tbl[i].exp_c);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].exp_busy);
    end

    // reset asserted at p=2 clears outputs without a clock edge
    @(negedge clk_4f);
    dat_valid = 1; dat_word = 32'hCAFEF00D; ctl_valid = 0; hold = 0;
    @(posedge clk_4f); #1;
    chk("rw_first", byte_out, 8'hCA);
    dat_valid = 0;
    @(posedge clk_4f); #1;
    @(posedge clk_4f); #1;
    chk("rw_p2_byte", byte_out, 8'hF0);
    #1 reset = 1'b0;
    #1;
    chk("rw_async_valid", byte_valid, 0);
    chk("rw_async_byte", byte_out, 8'h00);
    chk("rw_async_busy", busy, 0);
    @(negedge clk_4f); reset = 1'b1;
    dat_valid = 1; dat_word = 32'h55667788;
    #1 chk("rw_ready_after", dat_ready, 1);
    @(posedge clk_4f); #1;
    dat_valid = 0;
    chk("rw_restart_msb", byte_out, 8'h55);
    chk("rw_restart_valid", byte_valid, 1);
    @(posedge clk_4f); #1;
    chk("rw_restart_b2", byte_out, 8'h66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
